// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle pass/add/sub/logic ops and a WIDTH-step
// shift-add multiplier, with registered result, flag and zero outputs.
module alu_seq #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               flag_q, flag_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     step;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_flag;

    // Single-cycle datapath on the latched operands
    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        alu_res  = '0;
        alu_flag = 1'b0;
        case (op_q)
            3'b000: alu_res = a_q;
            3'b001: alu_res = b_q;
            3'b010: begin
                alu_res  = sum[WIDTH-1:0];
                alu_flag = sum[WIDTH];
            end
            3'b011: begin
                alu_res  = diff[WIDTH-1:0];
                alu_flag = diff[WIDTH];
            end
            3'b100: alu_res = a_q & b_q;
            3'b101: alu_res = a_q | b_q;
            3'b110: alu_res = a_q ^ b_q;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add multiplicand into the high half when the
    // current multiplier LSB is set, then shift the whole accumulator right.
    always_comb begin
        step     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, a_q} : '0);
        acc_step = {step, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flag_d   = flag_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = a;
                    b_d   = b;
                    op_d  = op;
                    cnt_d = '0;
                    if (op == 3'b111) begin
                        acc_d   = {{WIDTH{1'b0}}, b};
                        state_d = MUL;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                result_d = alu_res;
                flag_d   = alu_flag;
                zero_d   = (alu_res == '0);
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d = acc_step[WIDTH-1:0];
                    flag_d   = |acc_step[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_step[WIDTH-1:0] == '0);
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flag_q   <= flag_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == EXEC) || (state_q == MUL);
    assign done   = done_q;
    assign result = result_q;
    assign flag   = flag_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with literal expectations plus random
// traffic compared every cycle against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 6;
    localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, flag, zero;
    logic [W-1:0] result;

    int tests = 0;
    int fails = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done),
        .result(result), .flag(flag), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic void model_op(input logic [2:0] o,
                                     input logic [63:0] x,
                                     input logic [63:0] y,
                                     output logic [63:0] r,
                                     output logic f);
        logic [63:0] t;
        f = 1'b0;
        case (o)
            3'd0: r = x;
            3'd1: r = y;
            3'd2: begin t = x + y; r = t & MASK; f = (t >> W) != 0; end
            3'd3: begin r = (x - y) & MASK; f = (x < y); end
            3'd4: r = x & y;
            3'd5: r = x | y;
            3'd6: r = x ^ y;
            default: begin t = x * y; r = t & MASK; f = (t >> W) != 0; end
        endcase
    endfunction

    // Reference model: an accepted request completes after a fixed number
    // of edges with a value computed directly from the operation's meaning.
    logic        m_busy = 1'b0, m_done = 1'b0, m_flag = 1'b0, m_zero = 1'b1;
    logic [63:0] m_res = '0, p_res = '0;
    logic        p_flag = 1'b0;
    int          m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_res = '0;
            m_flag = 1'b0; m_zero = 1'b1; m_cnt = 0;
        end else if (m_busy) begin
            m_done = 1'b0;
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 1'b0;
                m_res  = p_res;
                m_flag = p_flag;
                m_zero = (p_res == 0);
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                model_op(op, 64'(a), 64'(b), p_res, p_flag);
                m_busy = 1'b1;
                m_cnt  = (op == 3'd7) ? W : 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_busy", busy, m_busy);
        chk("cmp_done", done, m_done);
        chk("cmp_result", result, m_res);
        chk("cmp_flag", flag, m_flag);
        chk("cmp_zero", zero, m_zero);
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom);
    endtask

    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (busy) bc++;
        end
        if (!done) chk("done_timeout", done, 1);
    endtask

    task automatic count_done(input int cycles, output int dc,
                              output logic [W-1:0] last);
        dc = 0;
        last = result;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) begin dc++; last = result; end
        end
    endtask

    int n, bc, dc;
    logic [W-1:0] last;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flag", flag, 0);
        chk("rst_zero", zero, 1);
        rst_n = 1'b1;

        issue(3'd0, 6'd45, 6'd3);
        wait_done(n, bc);
        chk("pass_latency", n + 1, 2);
        chk("pass_busy_cycles", bc, 1);
        chk("pass_result", result, 45);
        chk("pass_flag", flag, 0);
        chk("pass_zero", zero, 0);

        issue(3'd2, 6'd40, 6'd30);
        wait_done(n, bc);
        chk("add_result", result, 6);
        chk("add_flag", flag, 1);

        issue(3'd3, 6'd5, 6'd9);
        wait_done(n, bc);
        chk("sub_result", result, 60);
        chk("sub_flag", flag, 1);

        issue(3'd6, 6'd21, 6'd21);
        wait_done(n, bc);
        chk("xor_result", result, 0);
        chk("xor_zero", zero, 1);
        chk("xor_flag", flag, 0);

        issue(3'd7, 6'd7, 6'd9);
        wait_done(n, bc);
        chk("mul_latency", n + 1, 7);
        chk("mul_busy_cycles", bc, 6);
        chk("mul_result", result, 63);
        chk("mul_flag", flag, 0);

        issue(3'd7, 6'd9, 6'd8);
        wait_done(n, bc);
        chk("mul_ovf_result", result, 8);
        chk("mul_ovf_flag", flag, 1);

        issue(3'd7, 6'd7, 6'd9);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 6'd1; b = 6'd2;
        @(negedge clk);
        start = 1'b0;
        count_done(12, dc, last);
        chk("ignore_done_count", dc, 1);
        chk("ignore_result", last, 63);

        issue(3'd7, 6'd7, 6'd9);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_zero", zero, 1);
        chk("abort_done", done, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        count_done(10, dc, last);
        chk("abort_no_done", dc, 0);
        issue(3'd2, 6'd1, 6'd2);
        wait_done(n, bc);
        chk("after_abort_result", result, 3);

        issue(3'd2, 6'd1, 6'd1);
        @(negedge clk);
        chk("b2b_done1", done, 1);
        chk("b2b_result1", result, 2);
        start = 1'b1; op = 3'd0; a = 6'd17; b = 6'd0;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_gap", done, 0);
        @(negedge clk);
        chk("b2b_done2", done, 1);
        chk("b2b_result2", result, 17);

        repeat (600) begin
            @(negedge clk);
            start = ($urandom % 3) == 0;
            op    = 3'($urandom);
            a     = W'($urandom);
            b     = W'($urandom);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
Parameters
REQ-001 WIDTH, default 6, operand and result width in bits; legal range 2..32.

Ports
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only when the block is idle.
REQ-005 op  input  3  operation select, sampled with start.
REQ-006 a  input  WIDTH  operand A, sampled with start.
REQ-007 b  input  WIDTH  operand B, sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result  output  WIDTH  registered result of the last completed operation.
REQ-011 flag  output  1  carry, borrow or overflow of the last completed operation.
REQ-012 zero  output  1  high when result equals 0 (registered with result).

Function
REQ-013 The op encoding SHALL be:
  - 000 pass A; 001 pass B
  - 010 A+B; 011 A-B
  - 100 A&B; 101 A|B; 110 A^B
  - 111 unsigned A*B
REQ-014 The FSM SHALL have three states: IDLE, EXEC and MUL.
REQ-015 In IDLE, start=1 at a rising edge SHALL latch a, b and op into internal registers and move to MUL if op=111, otherwise to EXEC.
REQ-016 In IDLE, start=0 SHALL leave all state and outputs unchanged, except that done returns to 0.
REQ-017 EXEC SHALL, at the next edge, write result and flag, set zero, pulse done, and return to IDLE; latency is 2 edges from the start-sampling edge.
REQ-018 MUL SHALL run a shift-add multiply over exactly WIDTH edges (one partial product per edge, 2*WIDTH-bit accumulator).
REQ-019 On the last MUL edge, MUL SHALL write result, flag and zero, pulse done, and return to IDLE; latency is WIDTH+1 edges from the start-sampling edge.
REQ-020 busy SHALL equal 1 exactly when the state is EXEC or MUL.
REQ-021 done SHALL be high for exactly the one cycle following the completing edge.
REQ-022 start while busy=1 SHALL be ignored: no operand capture and no queuing.
REQ-023 start asserted in the same cycle done=1 (state IDLE) SHALL be accepted (back-to-back operation).
REQ-024 Operand changes on a and b after the start-sampling edge SHALL NOT affect the operation in progress.
REQ-025 Arithmetic results SHALL be truncated modulo 2^WIDTH.
REQ-026 Flag rules:
  - add: flag = carry out.
  - sub: flag = borrow (A<B unsigned).
  - mul: flag = 1 if product bits [2*WIDTH-1:WIDTH] are non-zero.
  - pass and logic operations: flag = 0.
REQ-027 result, flag and zero SHALL hold their values between completions.

Reset
REQ-028 rst_n=0 SHALL immediately force:
  - state = IDLE
  - busy = 0, done = 0
  - result = 0, flag = 0, zero = 1
  - internal operand and accumulator registers = 0
REQ-029 Reset mid-operation (EXEC or MUL) SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification (WIDTH=6)
REQ-030 Reset, then a=45, b=3, op=000, start pulse -> busy=1 for 1 cycle; done pulse with result=45, flag=0, zero=0, 2 edges after start.
REQ-031 Wrap cases:
  - add 40+30 -> result=6, flag=1.
  - sub 5-9 -> result=60, flag=1.
  - xor 21^21 -> result=0, zero=1, flag=0.
REQ-032 Multiply cases:
  - mul 7*9 -> done 7 edges after start, result=63, flag=0; busy high for 6 cycles.
  - mul 9*8 -> result=8, flag=1.
REQ-033 Start mul 7*9, then pulse start with op=010 on the 3rd busy cycle -> ignored; only one done pulse occurs, result=63.
REQ-034 Start mul 7*9, assert rst_n=0 on the 3rd busy cycle -> busy=0, result=0, zero=1, no done pulse; then a new add 1+2 -> result=3.
REQ-035 Back-to-back: add 1+1 with a second start (op=000, a=17) in the done cycle -> two done pulses 2 edges apart, results 2 then 17.
